// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES        = 4;
    localparam int unsigned XLEN               = 32;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Counters must hold the value DEPTH itself, hence the extra bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_FIFO_DEPTH) + 1;
    typedef logic [DEFAULT_CNT_W-1:0] fetch_cnt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, registered head (no bypass), used for the fetch buffer
// and the in-flight request-PC queue.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              data_i,
    input  logic                          pop_i,
    output logic [WIDTH-1:0]              data_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o,
    output logic                          empty_o,
    output logic                          full_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests, buffers
// responses and hands {pc, instr} to decode; EX redirects flush and restart fetch.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);

    localparam int unsigned CW = cnt_width(FIFO_DEPTH);
    localparam int unsigned EW = $bits(fetch_entry_t);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;     // outstanding requests, stale ones included
    logic [CW-1:0] disc_q, disc_d;   // leading responses still to be discarded
    logic [CW-1:0] buf_count, pcq_count;
    logic [CW:0]   credit_sum;
    logic          buf_empty, buf_full, pcq_empty, pcq_full;
    logic          req_fire, rsp_keep, id_pop;
    logic [31:0]   pcq_head;
    logic [EW-1:0] head_bits;
    fetch_entry_t  push_entry, head_entry;

    assign credit_sum     = {1'b0, out_q} + {1'b0, buf_count};
    assign imem_req_valid = !rst && !redirect_valid && (credit_sum < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep       = imem_rsp_valid && (disc_q == '0) && !redirect_valid;
    assign push_entry.pc    = pcq_head;
    assign push_entry.instr = imem_rsp_data;

    assign id_valid   = !buf_empty && !redirect_valid;
    assign id_pop     = id_valid && id_ready;
    assign head_entry = head_bits;
    assign id_pc      = head_entry.pc;
    assign id_instr   = head_entry.instr;

    // On redirect everything still in flight becomes stale and is counted off later.
    always_comb begin
        pc_d   = pc_q;
        disc_d = disc_q;
        out_d  = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            pc_d   = redirect_pc & ~32'(INSTR_BYTES - 1);
            disc_d = out_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) pc_d = pc_q + 32'(INSTR_BYTES);
            if (imem_rsp_valid && (disc_q != '0)) disc_d = disc_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            disc_q <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            disc_q <= disc_d;
        end
    end

    fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (rsp_keep),
        .data_i  (push_entry),
        .pop_i   (id_pop),
        .data_o  (head_bits),
        .count_o (buf_count),
        .empty_o (buf_empty),
        .full_o  (buf_full)
    );

    // PCs of live (non-stale) requests, popped as their responses return.
    fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_pcq (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (req_fire),
        .data_i  (pc_q),
        .pop_i   (rsp_keep),
        .data_o  (pcq_head),
        .count_o (pcq_count),
        .empty_o (pcq_empty),
        .full_o  (pcq_full)
    );

    a_buf_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(rsp_keep && buf_full));
    a_pcq_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(req_fire && pcq_full));
    a_pcq_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        !(rsp_keep && pcq_empty));
    a_out_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (out_q == '0)));
    a_pcq_tracks_live: assert property (@(posedge clk) disable iff (rst)
        pcq_count == (out_q - disc_q));
    a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
        imem_req_addr[1:0] == 2'b00);

endmodule
